// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: arbiter state type and default serial timing.
// Shared by uart_tx_arbiter and uart_arb_timer.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      GAP
   } arb_state_e;

   localparam int CLK_HZ     = 50_000_000;
   localparam int BAUD       = 115200;
   localparam int BIT_CYCLES = CLK_HZ / BAUD;

   // Counter width for a terminal value n, never below one bit.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/uart_arb_timer.sv
// uart_arb_timer: loadable down-counter, saturating at zero.
// tc_o marks the enabled cycle that takes the count from 1 to 0.
module uart_arb_timer
   import uart_arb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i & ~load_i & (cnt_q == W'(1));

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular two-source arbiter for one tx engine.
// Define ARB_FIXED_PRIO_EN for fixed priority (source 0 wins), else round-robin.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int GAP_CYCLES     = 10 * BIT_CYCLES,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_valid,
   input  logic              s0_last,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_valid,
   input  logic              s1_last,
   output logic              s1_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_data_valid,
   input  logic              tx_data_ready,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int GW = cnt_w(GAP_CYCLES);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);

   arb_state_e state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       done_q, done_d;
   logic       abort_q, abort_d;

   logic sel_valid, sel_last, hs, pick;
   logic gap_load, gap_en, gap_tc;
   logic wd_load, wd_en, wd_tc;

   assign sel_valid = (grant_q[0] & s0_valid) | (grant_q[1] & s1_valid);
   assign sel_last  = (grant_q[0] & s0_last) | (grant_q[1] & s1_last);
   assign hs        = sel_valid & tx_data_ready;

`ifdef ARB_FIXED_PRIO_EN
   assign pick = ~s0_valid;
`else
   logic rr_next_q;

   assign pick = (s0_valid & s1_valid) ? rr_next_q : s1_valid;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_next_q <= 1'b0;
      end else if (state_q == IDLE && (s0_valid | s1_valid)) begin
         rr_next_q <= ~pick;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      gap_load = 1'b0;
      gap_en   = 1'b0;
      wd_load  = 1'b0;
      wd_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s0_valid | s1_valid) begin
               state_d = XFER;
               grant_d = pick ? 2'b10 : 2'b01;
               wd_load = 1'b1;
            end
         end
         XFER: begin
            // A last-byte handshake needs valid high, so it beats the watchdog.
            if (hs & sel_last) begin
               done_d = 1'b1;
            end else if (sel_valid) begin
               wd_load = 1'b1;
            end else begin
               wd_en   = 1'b1;
               abort_d = wd_tc;
            end
            if (done_d | abort_d) begin
               grant_d = 2'b00;
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d  = GAP;
                  gap_load = 1'b1;
               end
            end
         end
         GAP: begin
            gap_en = 1'b1;
            if (gap_tc) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   uart_arb_timer #(.W(GW)) u_gap (
      .clk_i      (sys_clk),
      .rst_ni     (rst_n),
      .load_i     (gap_load),
      .load_val_i (GW'(GAP_CYCLES)),
      .en_i       (gap_en),
      .tc_o       (gap_tc)
   );

   uart_arb_timer #(.W(TW)) u_wdog (
      .clk_i      (sys_clk),
      .rst_ni     (rst_n),
      .load_i     (wd_load),
      .load_val_i (TW'(TIMEOUT_CYCLES)),
      .en_i       (wd_en),
      .tc_o       (wd_tc)
   );

   assign tx_data       = grant_q[1] ? s1_data : (grant_q[0] ? s0_data : '0);
   assign tx_data_valid = sel_valid;
   assign s0_ready      = grant_q[0] & tx_data_ready;
   assign s1_ready      = grant_q[1] & tx_data_ready;
   assign grant         = grant_q;
   assign busy          = (state_q != IDLE);
   assign frame_done    = done_q;
   assign frame_abort   = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, corner sequences and randomized
// frame traffic against a cycle-count reference model.
module tb_uart_tx_arbiter;

`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int GAP = 3;
   localparam int TMO = 16;

   logic       sys_clk, rst_n;
   logic [7:0] s0_data, s1_data;
   logic       s0_valid, s0_last, s1_valid, s1_last, tx_data_ready;

   logic [7:0] a_tx_data, b_tx_data;
   logic       a_tx_data_valid, a_s0_ready, a_s1_ready, a_busy;
   logic       a_frame_done, a_frame_abort;
   logic [1:0] a_grant, b_grant;
   logic       b_tx_data_valid, b_s0_ready, b_s1_ready, b_busy;
   logic       b_frame_done, b_frame_abort;

   int n_chk = 0;
   int n_pass = 0;
   int win_q[$];

   uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) u_a (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
      .s0_ready(a_s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
      .s1_ready(a_s1_ready),
      .tx_data(a_tx_data), .tx_data_valid(a_tx_data_valid),
      .tx_data_ready(tx_data_ready), .grant(a_grant), .busy(a_busy),
      .frame_done(a_frame_done), .frame_abort(a_frame_abort)
   );

   uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) u_b (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
      .s0_ready(b_s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
      .s1_ready(b_s1_ready),
      .tx_data(b_tx_data), .tx_data_valid(b_tx_data_valid),
      .tx_data_ready(tx_data_ready), .grant(b_grant), .busy(b_busy),
      .frame_done(b_frame_done), .frame_abort(b_frame_abort)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // {grant[1:0], busy, tx_valid, s0_ready, s1_ready, done, abort}
   function automatic logic [7:0] a_st();
      return {a_grant, a_busy, a_tx_data_valid, a_s0_ready, a_s1_ready,
              a_frame_done, a_frame_abort};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clr_in();
      s0_valid = 0; s0_data = 0; s0_last = 0;
      s1_valid = 0; s1_data = 0; s1_last = 0;
      tx_data_ready = 0;
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 0;
      repeat (2) @(posedge sys_clk);
      #1 rst_n = 1;
   endtask

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       l0;
      logic       v1;
      logic [7:0] d1;
      logic       l1;
      logic       txr;
      logic [7:0] e_st;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0,
                               logic v1, logic [7:0] d1, logic l1,
                               logic txr, logic [7:0] e_st,
                               logic [7:0] e_data);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.l0 = l0;
      v.v1 = v1; v.d1 = d1; v.l1 = l1;
      v.txr = txr; v.e_st = e_st; v.e_data = e_data;
      return v;
   endfunction

   // Model: grant follows arbitration by one cycle; a frame ending at
   // cycle c leaves the arbiter busy through c+GAP, idle from c+GAP+1.
   task automatic run_traffic(input int nfr, input int minlen,
                              input int maxlen, input int stall_pct,
                              input int txr_per);
      bit         pv[2];
      bit         lst[2];
      bit         acc[2];
      logic [7:0] cur[2];
      int         left[2];
      int         fr[2];
      int         stall[2];
      bit         m_busy, pref, hs;
      int         owner, m_gstart, m_idle_from, m_done_at, ndone, cyc;
      logic [1:0] eg;
      logic [7:0] e;
      do_reset();
      win_q.delete();
      for (int s = 0; s < 2; s++) begin
         pv[s] = 0; lst[s] = 0; cur[s] = 0;
         left[s] = 0; fr[s] = nfr; stall[s] = 0;
      end
      m_busy = 0; pref = 0; owner = 0; m_gstart = 0;
      m_idle_from = 0; m_done_at = -1; ndone = 0; cyc = 0;
      while (ndone < 2 * nfr && cyc < 4000) begin
         for (int s = 0; s < 2; s++) begin
            if (!pv[s]) begin
               if (left[s] == 0 && fr[s] > 0) begin
                  left[s] = int'($urandom_range(minlen, maxlen));
                  fr[s]--;
               end
               if (left[s] > 0) begin
                  if (stall[s] < 4 &&
                      int'($urandom_range(0, 99)) < stall_pct) begin
                     stall[s]++;
                  end else begin
                     pv[s] = 1; stall[s] = 0;
                     cur[s] = 8'($urandom);
                     lst[s] = (left[s] == 1);
                  end
               end
            end
         end
         s0_valid = pv[0]; s0_data = cur[0]; s0_last = lst[0];
         s1_valid = pv[1]; s1_data = cur[1]; s1_last = lst[1];
         if (txr_per == 0) tx_data_ready = 1'($urandom_range(0, 1));
         else tx_data_ready = ((cyc % txr_per) == txr_per - 1);
         @(negedge sys_clk);
         eg = (m_busy && cyc >= m_gstart) ? (owner != 0 ? 2'b10 : 2'b01)
                                          : 2'b00;
         hs = (eg != 2'b00) && pv[owner] && tx_data_ready;
         e = {eg, (m_busy && cyc >= m_gstart) || (cyc < m_idle_from),
              (eg != 2'b00) && pv[owner], eg[0] && tx_data_ready,
              eg[1] && tx_data_ready, cyc == m_done_at, 1'b0};
         chk($sformatf("traffic status c%0d", cyc), 32'(a_st()), 32'(e));
         if ((eg != 2'b00) && pv[owner])
            chk($sformatf("traffic data c%0d", cyc), 32'(a_tx_data),
                32'(cur[owner]));
         acc[0] = 0; acc[1] = 0;
         if (hs) begin
            acc[owner] = 1;
            if (lst[owner]) begin
               m_busy = 0;
               m_done_at = cyc + 1;
               m_idle_from = cyc + GAP + 1;
               ndone++;
            end
         end else if (!m_busy && cyc >= m_idle_from && (pv[0] || pv[1])) begin
            if (pv[0] && pv[1]) owner = FIXED ? 0 : int'(pref);
            else owner = pv[1] ? 1 : 0;
            pref = (owner == 0);
            m_busy = 1;
            m_gstart = cyc + 1;
            win_q.push_back(owner);
         end
         tick();
         for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
               pv[s] = 0;
               left[s]--;
            end
         end
         cyc++;
      end
      chk("traffic frames delivered", 32'(ndone), 32'(2 * nfr));
      clr_in();
   endtask

   initial begin
      clr_in();
      rst_n = 1;
      tbl[0]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
      tbl[1]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 8'h78, 8'h11);
      tbl[2]  = mk(1, 8'h22, 0, 0, 8'h00, 0, 1, 8'h78, 8'h22);
      tbl[3]  = mk(1, 8'h33, 1, 0, 8'h00, 0, 1, 8'h78, 8'h33);
      tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h22, 8'h00);
      tbl[5]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h20, 8'h00);
      tbl[6]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h20, 8'h00);
      tbl[7]  = mk(0, 8'h00, 0, 1, 8'hA5, 1, 1, 8'h00, 8'h00);
      tbl[8]  = mk(0, 8'h00, 0, 1, 8'hA5, 1, 0, 8'hB0, 8'hA5);
      tbl[9]  = mk(0, 8'h00, 0, 1, 8'hA5, 1, 1, 8'hB4, 8'hA5);
      tbl[10] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h22, 8'h00);

      #2 rst_n = 0;
      @(negedge sys_clk);
      chk("reset status", 32'(a_st()), 32'(8'h00));
      chk("reset tx_data", 32'(a_tx_data), 32'(8'h00));

      do_reset();
      for (int i = 0; i < 11; i++) begin
         s0_valid = tbl[i].v0; s0_data = tbl[i].d0; s0_last = tbl[i].l0;
         s1_valid = tbl[i].v1; s1_data = tbl[i].d1; s1_last = tbl[i].l1;
         tx_data_ready = tbl[i].txr;
         @(negedge sys_clk);
         chk($sformatf("vec%0d status", i), 32'(a_st()), 32'(tbl[i].e_st));
         chk($sformatf("vec%0d data", i), 32'(a_tx_data),
             32'(tbl[i].e_data));
         tick();
      end

      do_reset();
      s1_valid = 1; s1_data = 8'hC1; s1_last = 0; tx_data_ready = 1;
      tick();
      @(negedge sys_clk);
      chk("abort first grant", 32'(a_grant), 32'(2'b10));
      tick();
      s1_valid = 0;
      repeat (15) tick();
      @(negedge sys_clk);
      chk("abort before expiry", 32'(a_st()), 32'(8'b1010_0100));
      tick();
      s1_valid = 1; s1_data = 8'hC2; s1_last = 1;
      @(negedge sys_clk);
      chk("abort pulse", 32'(a_st()), 32'(8'b0010_0001));
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge sys_clk);
         chk($sformatf("abort wait%0d", k), 32'(a_st()),
             32'(k < 2 ? 8'h20 : 8'h00));
      end
      tick();
      @(negedge sys_clk);
      chk("abort regrant", 32'({a_st(), a_tx_data}),
          32'({8'b1011_0100, 8'hC2}));
      tick();
      clr_in();

      do_reset();
      s0_valid = 1; s0_data = 8'hD1; s0_last = 1; tx_data_ready = 1;
      tick();
      @(negedge sys_clk);
      chk("gap0 first grant", 32'(b_grant), 32'(2'b01));
      tick();
      s0_data = 8'hD2;
      @(negedge sys_clk);
      chk("gap0 frame end", 32'({b_grant, b_busy, b_frame_done}),
          32'({2'b00, 1'b0, 1'b1}));
      chk("gap0 gapped busy", 32'(a_busy), 32'(1'b1));
      tick();
      @(negedge sys_clk);
      chk("gap0 second grant", 32'({b_grant, b_tx_data}),
          32'({2'b01, 8'hD2}));
      tick();
      clr_in();

      do_reset();
      s0_valid = 1; s0_data = 8'hE1; s0_last = 0;
      s1_valid = 1; s1_data = 8'hF1; s1_last = 1; tx_data_ready = 1;
      tick();
      @(negedge sys_clk);
      chk("rst pre grant", 32'(a_grant), 32'(2'b01));
      tick();
      s0_data = 8'hE2;
      #2 rst_n = 0;
      #1;
      chk("rst async outputs",
          32'({a_grant, a_busy, a_tx_data_valid, a_s0_ready, a_s1_ready,
               b_grant, b_busy, b_tx_data_valid, b_s0_ready, b_s1_ready,
               b_frame_abort}), 32'(0));
      chk("rst async tx_data", 32'(a_tx_data), 32'(0));
      @(posedge sys_clk);
      #1 rst_n = 1;
      @(negedge sys_clk);
      chk("rst idle", 32'(a_st()), 32'(8'h00));
      tick();
      @(negedge sys_clk);
      chk("rst restart grant", 32'({a_grant, a_tx_data}),
          32'({2'b01, 8'hE2}));
      tick();
      clr_in();

      run_traffic(4, 2, 2, 0, 1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr order %0d", i),
             32'(i < win_q.size() ? win_q[i] : 9),
             32'(FIXED ? 0 : (i % 2)));

      run_traffic(1, 4, 4, 0, 8);
      run_traffic(20, 1, 4, 25, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
